// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if: handshake and data bundle between the EX stage and the
// iterative divider. The master side is the pipeline, the slave side is
// the divider itself.
interface ex_div_unit_if #(
   parameter int DIV_W = 32
);
   logic               start;
   logic               is_signed;
   logic [DIV_W-1:0]   dividend;
   logic [DIV_W-1:0]   divisor;
   logic               cancel;
   logic               pipe_stall;
   logic               stall;
   logic               done;
   logic [2*DIV_W-1:0] hilo_out;

   modport master (
      output start, is_signed, dividend, divisor, cancel, pipe_stall,
      input  stall, done, hilo_out
   );

   modport slave (
      input  start, is_signed, dividend, divisor, cancel, pipe_stall,
      output stall, done, hilo_out
   );
endinterface

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring divider for MIPS DIV/DIVU in EX.
// One quotient bit per cycle on unsigned magnitudes, sign correction when
// the result is latched into hilo_out = {HI = remainder, LO = quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and
// presents the divide-by-zero result one cycle after start.
module ex_div_unit #(
   parameter int DIV_W = 32,
   parameter int CNT_W = 5
) (
   input logic          clk,
   input logic          rst_n,
   ex_div_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [2*DIV_W-1:0] rem_q;
   logic [DIV_W-1:0]   div_mag;
   logic               neg_quot;
   logic               neg_rem;
   logic [2*DIV_W-1:0] hilo_q;
   logic               done_q;

   logic               start_neg_a;
   logic               start_neg_b;
   logic [DIV_W-1:0]   start_mag_a;
   logic [DIV_W-1:0]   start_mag_b;

   logic [DIV_W-1:0]   upper_shift;
   logic [DIV_W-1:0]   trial;
   logic               trial_ok;
   logic [2*DIV_W-1:0] rem_next;
   logic               accept;

   // Applies the MIPS sign rules to a raw {remainder, quotient} magnitude pair
   function automatic logic [2*DIV_W-1:0] fix_sign(
      input logic [2*DIV_W-1:0] raw,
      input logic               nq,
      input logic               nr
   );
      logic [DIV_W-1:0] hi;
      logic [DIV_W-1:0] lo;
      hi = raw[2*DIV_W-1:DIV_W];
      lo = raw[DIV_W-1:0];
      if (nr) hi = ~hi + DIV_W'(1);
      if (nq) lo = ~lo + DIV_W'(1);
      return {hi, lo};
   endfunction

   // Operand signs and magnitudes as seen at the start cycle
   always_comb begin
      start_neg_a = bus.is_signed & bus.dividend[DIV_W-1];
      start_neg_b = bus.is_signed & bus.divisor[DIV_W-1];
      start_mag_a = start_neg_a ? (~bus.dividend + DIV_W'(1)) : bus.dividend;
      start_mag_b = start_neg_b ? (~bus.divisor + DIV_W'(1)) : bus.divisor;
      accept      = (state == IDLE) & bus.start & ~bus.cancel;
   end

   // One restoring step: the shifted upper half is 33 bits wide, its top bit
   // lives in rem_q[63], so a set top bit always means the subtraction fits
   always_comb begin
      upper_shift = rem_q[2*DIV_W-2:DIV_W-1];
      trial       = upper_shift - div_mag;
      trial_ok    = rem_q[2*DIV_W-1] | (upper_shift >= div_mag);
      rem_next    = trial_ok ? {trial, rem_q[DIV_W-2:0], 1'b1}
                             : {rem_q[2*DIV_W-2:0], 1'b0};
   end

   // Stall is combinational so it is already high in the start cycle, and
   // it is held low whenever reset is asserted
   always_comb begin
      bus.stall = rst_n & (accept | (state == BUSY));
   end

   assign bus.done     = done_q;
   assign bus.hilo_out = hilo_q;

   // Control FSM plus datapath registers; results are latched on entry to DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         rem_q    <= '0;
         div_mag  <= '0;
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
         hilo_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  rem_q    <= {{DIV_W{1'b0}}, start_mag_a};
                  div_mag  <= start_mag_b;
                  neg_quot <= start_neg_a ^ start_neg_b;
                  neg_rem  <= start_neg_a;
                  count    <= '0;
`ifdef DIV_ZERO_FAST_EN
                  if (bus.divisor == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     hilo_q <= fix_sign({start_mag_a, {DIV_W{1'b1}}},
                                        start_neg_a ^ start_neg_b, start_neg_a);
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end

            BUSY: begin
               if (bus.cancel) begin
                  state <= IDLE;
                  count <= '0;
               end else begin
                  rem_q <= rem_next;
                  count <= count + 1'b1;
                  if (count == CNT_W'(DIV_W - 1)) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     hilo_q <= fix_sign(rem_next, neg_quot, neg_rem);
                  end
               end
            end

            DONE: begin
               if (bus.cancel || !bus.pipe_stall) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
